seg_595_rx: RTL

SEG_595_RX -- requirements
Module: seg_595_rx

---
 rtl/seg_595_rx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg_595_rx.sv
// Receiver that snoops a 74HC595 serial link and rebuilds a six-digit seven-segment display.
// Latency: digit update and frame_vld/err land on the 4th sys_clk rise after stcp is first sampled high.
module seg_595_rx (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        ds,
  input  logic        oe,
  output logic [29:0] digits,
  output logic [5:0]  point,
  output logic        frame_vld,
  output logic        scan_done,
  output logic        err,
  output logic [7:0]  err_cnt
);

  logic [2:0]  shcp_q, stcp_q;
  logic [1:0]  ds_q, oe_q;
  logic [1:0]  warm;
  logic        shcp_rise, stcp_rise;
  logic [13:0] sr, frame_q;
  logic [3:0]  bit_cnt;
  logic        pend, len_ok, oe_lat;
  logic [5:0]  mask, sel_n, mask_nxt;
  logic [7:0]  seg;
  logic [4:0]  code;
  logic        one_sel, accept, reject;

  // Edges stay masked until the third stage holds a genuine post-reset sample,
  // so a line that is already high at release is not mistaken for a rise.
  assign shcp_rise = (warm == 2'd3) && shcp_q[1] && !shcp_q[2];
  assign stcp_rise = (warm == 2'd3) && stcp_q[1] && !stcp_q[2];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shcp_q <= '0;
      stcp_q <= '0;
      ds_q   <= '0;
      oe_q   <= '0;
      warm   <= '0;
    end else begin
      shcp_q <= {shcp_q[1:0], shcp};
      stcp_q <= {stcp_q[1:0], stcp};
      ds_q   <= {ds_q[0], ds};
      oe_q   <= {oe_q[0], oe};
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      frame_q <= '0;
      pend    <= 1'b0;
      len_ok  <= 1'b0;
      oe_lat  <= 1'b0;
    end else begin
      pend <= stcp_rise;
      if (stcp_rise) begin
        frame_q <= sr;
        len_ok  <= (bit_cnt == 4'd14);
        oe_lat  <= oe_q[1];
      end
      if (shcp_rise) sr <= {sr[12:0], ds_q[1]};
      // A simultaneous shift belongs to the next frame, so it is already bit 1.
      if (stcp_rise)
        bit_cnt <= shcp_rise ? 4'd1 : 4'd0;
      else if (shcp_rise && bit_cnt != 4'd15)
        bit_cnt <= bit_cnt + 4'd1;
    end
  end

  assign seg      = frame_q[13:6];
  assign sel_n    = ~frame_q[5:0];
  assign one_sel  = (sel_n != 6'd0) && ((sel_n & (sel_n - 6'd1)) == 6'd0);
  assign accept   = pend && len_ok && !oe_lat && one_sel;
  assign reject   = pend && !accept;
  assign mask_nxt = mask | sel_n;

  always_comb begin
    code = 5'd31;
    case (seg[6:0])
      7'h40: code = 5'd0;
      7'h79: code = 5'd1;
      7'h24: code = 5'd2;
      7'h30: code = 5'd3;
      7'h19: code = 5'd4;
      7'h12: code = 5'd5;
      7'h02: code = 5'd6;
      7'h78: code = 5'd7;
      7'h00: code = 5'd8;
      7'h10: code = 5'd9;
      7'h08: code = 5'd10;
      7'h03: code = 5'd11;
      7'h46: code = 5'd12;
      7'h21: code = 5'd13;
      7'h06: code = 5'd14;
      7'h0E: code = 5'd15;
      7'h7F: code = 5'd16;
      7'h3F: code = 5'd17;
      default: code = 5'd31;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      digits    <= {6{5'd16}};
      point     <= '0;
      mask      <= '0;
      frame_vld <= 1'b0;
      scan_done <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_vld <= accept;
      err       <= reject;
      scan_done <= accept && (mask_nxt == 6'h3F);
      if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (accept) begin
        for (int k = 0; k < 6; k++) begin
          if (sel_n[k]) begin
            digits[5*k +: 5] <= code;
            point[k]         <= ~seg[7];
          end
        end
        mask <= (mask_nxt == 6'h3F) ? 6'd0 : mask_nxt;
      end
    end
  end

endmodule
